// File: rtl/zaxxon_snd_pkg.sv
// zaxxon_snd_pkg: shared widths, default duration table and voice state for the sound scheduler
package zaxxon_snd_pkg;
  localparam int NUM_TRIG = 8;
  localparam int TW = 3;
  localparam int DUR_W = 10;
  localparam logic [NUM_TRIG-1:0][DUR_W-1:0] DEFAULT_DUR = {
    10'd0, 10'd150, 10'd500, 10'd50, 10'd300, 10'd80, 10'd120, 10'd200
  };
  typedef struct packed {
    logic             active;
    logic [TW-1:0]    sel;
    logic [DUR_W-1:0] cnt;
  } voice_t;
  function automatic logic [3:0] gain_of(input logic [DUR_W-1:0] cnt, input int shift);
    logic [DUR_W-1:0] s;
    s = cnt >> shift;
    return |s[DUR_W-1:4] ? 4'hf : s[3:0];
  endfunction
endpackage

// File: rtl/zaxxon_snd_voice.sv
// zaxxon_snd_voice: one voice slot with load, tick countdown, expiry and registered gain
module zaxxon_snd_voice
  import zaxxon_snd_pkg::*;
#(
  parameter int GAIN_SHIFT = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [TW-1:0]    load_sel,
  input  logic [DUR_W-1:0] load_dur,
  output logic             active,
  output logic [TW-1:0]    sel,
  output logic             start,
  output logic [3:0]       gain
);
  voice_t st, nxt;
  assign nxt = load ? '{1'b1, load_sel, load_dur} :
               (tick && st.active) ? '{st.cnt != DUR_W'(1), st.sel, st.cnt - 1'b1} : st;
  assign active = st.active;
  assign sel = st.sel;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st <= '0;
      start <= 1'b0;
      gain <= '0;
    end else begin
      st <= nxt;
      start <= load;
      gain <= nxt.active ? gain_of(nxt.cnt, GAIN_SHIFT) : 4'd0;
    end
  end
endmodule

// File: rtl/zaxxon_sound_scheduler.sv
// zaxxon_sound_scheduler: edge-detects sound triggers, queues them and allocates them onto shared voice slots
module zaxxon_sound_scheduler
  import zaxxon_snd_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int TICK_DIV = 48000,
  parameter int GAIN_SHIFT = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NUM_TRIG-1:0]      trig,
  input  logic                     cfg_we,
  input  logic [TW-1:0]            cfg_addr,
  input  logic [DUR_W-1:0]         cfg_dur,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic [NUM_VOICES*TW-1:0] voice_sel,
  output logic [NUM_VOICES-1:0]    voice_start,
  output logic [NUM_VOICES*4-1:0]  voice_gain,
  output logic                     drop
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [NUM_TRIG-1:0] trig_q, pend, rise, clr;
  logic [NUM_TRIG-1:0][DUR_W-1:0] dur;
  logic [PW-1:0] pre;
  logic tick, any_pend, zero_dur, take;
  logic [TW-1:0] win;
  logic [NUM_VOICES-1:0] match, free, match_1h, free_1h, load;
  assign rise = trig & ~trig_q;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_comb begin
    win = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) win = pend[i] ? TW'(i) : win;
  end
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign match[v] = voice_active[v] && voice_sel[v*TW +: TW] == win;
    assign free[v] = !voice_active[v];
    zaxxon_snd_voice #(.GAIN_SHIFT(GAIN_SHIFT)) u_voice (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick),
      .load    (load[v]),
      .load_sel(win),
      .load_dur(dur[win]),
      .active  (voice_active[v]),
      .sel     (voice_sel[v*TW +: TW]),
      .start   (voice_start[v]),
      .gain    (voice_gain[v*4 +: 4])
    );
  end
  // retrigger an already-playing slot first, otherwise take the lowest free one; never steal
  assign match_1h = match & (~match + 1'b1);
  assign free_1h = free & (~free + 1'b1);
  assign any_pend = |pend;
  assign zero_dur = dur[win] == '0;
  assign load = (!any_pend || zero_dur) ? '0 : |match ? match_1h : free_1h;
  assign take = any_pend && (zero_dur || |load);
  assign clr = take ? NUM_TRIG'(1) << win : '0;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      trig_q <= '1;
      pend <= '0;
      pre <= '0;
      dur <= DEFAULT_DUR;
      drop <= 1'b0;
    end else begin
      trig_q <= trig;
      pend <= (pend & ~clr) | rise;
      pre <= tick ? '0 : pre + 1'b1;
      drop <= |(rise & pend & ~clr);
      if (cfg_we) dur[cfg_addr] <= cfg_dur;
    end
  end
endmodule

// File: tb/tb_zaxxon_sound_scheduler.sv
// tb_zaxxon_sound_scheduler: directed vectors with hand-computed expectations, TICK_DIV=4
module tb_zaxxon_sound_scheduler;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [7:0] trig = 8'h01;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [9:0] cfg_dur = '0;
  logic [1:0] voice_active, voice_start;
  logic [5:0] voice_sel;
  logic [7:0] voice_gain;
  logic drop;
  int cyc = 0, n_vec = 0, n_bad = 0;
  always #5 clk_sys = ~clk_sys;
  zaxxon_sound_scheduler #(.NUM_VOICES(2), .TICK_DIV(4), .GAIN_SHIFT(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .trig        (trig),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_dur     (cfg_dur),
    .voice_active(voice_active),
    .voice_sel   (voice_sel),
    .voice_start (voice_start),
    .voice_gain  (voice_gain),
    .drop        (drop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask
  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_act"}, voice_active, 0);
    chk({tag, "_start"}, voice_start, 0);
    chk({tag, "_sel"}, voice_sel, 0);
    chk({tag, "_gain"}, voice_gain, 0);
    chk({tag, "_drop"}, drop, 0);
  endtask
  initial begin
    repeat (3) step();
    chk_zero("rst");
    reset = 1'b0;
    cyc = 0;
    repeat (4) begin
      step();
      chk("nofire_start", voice_start, 0);
      chk("nofire_act", voice_active, 0);
    end
    trig = 8'h00; step();
    trig = 8'h04; step();
    chk("b2_lat_start", voice_start, 0);
    step();
    chk("b2_start", voice_start, 2'b01);
    chk("b2_act", voice_active, 2'b01);
    chk("b2_sel", voice_sel[2:0], 2);
    chk("b2_gain", voice_gain[3:0], 5);
    step();
    chk("b2_start_pulse", voice_start, 0);
    run_to(263);
    chk("b2_gain16", voice_gain[3:0], 1);
    step();
    chk("b2_gain15", voice_gain[3:0], 0);
    run_to(323);
    chk("b2_last_act", voice_active, 2'b01);
    step();
    chk("b2_expired", voice_active, 0);
    trig = 8'h00; step();
    trig = 8'h0A; step();
    chk("b13_lat_start", voice_start, 0);
    step();
    chk("b1_act", voice_active, 2'b01);
    chk("b1_start", voice_start, 2'b01);
    chk("b1_sel", voice_sel[2:0], 1);
    chk("b1_gain", voice_gain[3:0], 7);
    step();
    chk("b3_act", voice_active, 2'b11);
    chk("b3_start", voice_start, 2'b10);
    chk("b3_sel", voice_sel[5:3], 3);
    chk("b3_gain_clamp", voice_gain[7:4], 15);
    trig = 8'h08; step();
    trig = 8'h0A; step();
    chk("rt_lat_start", voice_start, 0);
    step();
    chk("rt_start", voice_start, 2'b01);
    chk("rt_act", voice_active, 2'b11);
    chk("rt_sel0", voice_sel[2:0], 1);
    chk("rt_sel1", voice_sel[5:3], 3);
    chk("rt_gain", voice_gain[3:0], 7);
    run_to(340);
    trig = 8'h1A; step();
    chk("b4_first_drop", drop, 0);
    run_to(345);
    trig = 8'h0A; step();
    trig = 8'h1A; step();
    chk("b4_drop", drop, 1);
    step();
    chk("b4_drop_pulse", drop, 0);
    while (cyc < 807) begin
      step();
      chk("held_start", voice_start, 0);
    end
    chk("held_act", voice_active, 2'b11);
    chk("held_sel0", voice_sel[2:0], 1);
    step();
    chk("s0_expire_act", voice_active, 2'b10);
    chk("s0_expire_start", voice_start, 0);
    step();
    chk("b4_act", voice_active, 2'b11);
    chk("b4_start", voice_start, 2'b01);
    chk("b4_sel", voice_sel[2:0], 4);
    chk("b4_gain", voice_gain[3:0], 3);
    run_to(1010);
    chk("b4_done", voice_active, 2'b10);
    trig = 8'h00; cfg_we = 1'b1; cfg_addr = 3'd7; cfg_dur = 10'd0; step();
    cfg_we = 1'b0; trig = 8'h80; step();
    chk("b7off_start_a", voice_start, 0);
    step();
    chk("b7off_start_b", voice_start, 0);
    chk("b7off_act", voice_active, 2'b10);
    step();
    chk("b7off_start_c", voice_start, 0);
    trig = 8'h00; cfg_we = 1'b1; cfg_dur = 10'd10; step();
    cfg_we = 1'b0; trig = 8'h80; step();
    chk("b7_no_drop", drop, 0);
    chk("b7_lat_start", voice_start, 0);
    step();
    chk("b7_start", voice_start, 2'b01);
    chk("b7_act", voice_active, 2'b11);
    chk("b7_sel", voice_sel[2:0], 7);
    chk("b7_gain", voice_gain[3:0], 0);
    chk("b7_drop", drop, 0);
    run_to(1055);
    chk("b7_last_act", voice_active[0], 1);
    step();
    chk("b7_expired", voice_active[0], 0);
    run_to(1060);
    reset = 1'b1; trig = 8'h00; step();
    chk_zero("midrst");
    step();
    reset = 1'b0;
    cyc = 0;
    step();
    trig = 8'h80; step();
    chk("post_b7_start_a", voice_start, 0);
    step();
    chk("post_b7_start_b", voice_start, 0);
    chk("post_b7_act", voice_active, 0);
    trig = 8'h84; step();
    chk("post_b2_lat", voice_start, 0);
    step();
    chk("post_b2_start", voice_start, 2'b01);
    chk("post_b2_sel", voice_sel[2:0], 2);
    chk("post_b2_gain", voice_gain[3:0], 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
